// File: rtl/multi_debounce.sv
// N-channel push-button conditioner: two-flop synchroniser, counter-based
// stability filter, registered debounced level, one-cycle press/release
// pulses and an optional one-shot long-press pulse per channel.
module multi_debounce #(
  parameter int NUM_CH        = 2,
  parameter int STABLE_CYCLES = 5,
  parameter int LONG_CYCLES   = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_en,
  input  logic [NUM_CH-1:0] btn_in,
  output logic [NUM_CH-1:0] btn_level,
  output logic [NUM_CH-1:0] btn_rise,
  output logic [NUM_CH-1:0] btn_fall,
  output logic [NUM_CH-1:0] btn_long
);

  localparam int CNT_W  = $clog2(STABLE_CYCLES + 1);
  // A zero-width counter is illegal, so keep at least one bit even when the
  // long-press feature is disabled (the counter is not built in that case).
  localparam int HOLD_W = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

  localparam logic [CNT_W-1:0]  STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  // Saturating increment of the hold counter; it parks at LONG_CYCLES so a
  // single press can never produce a second long pulse.
  function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
    sat_inc = (v == HOLD_MAX) ? v : v + HOLD_W'(1);
  endfunction

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;

  // Stage 0/1 boundary: two-flop synchroniser, runs every clock regardless of strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [CNT_W-1:0] stab_cnt;
    logic             level_q;
    logic             rise_q;
    logic             fall_q;
    logic             flip;

    // The level changes on this strobe: the synchronised input has disagreed
    // with the level for STABLE_CYCLES consecutive strobed samples.
    assign flip = sample_en && (sync2[ch] != level_q) && (stab_cnt == STAB_LAST);

    // Stage 2 boundary: stability filter, debounced level and edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stab_cnt <= '0;
        level_q  <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (sample_en) begin
          if (sync2[ch] == level_q) begin
            stab_cnt <= '0;
          end else if (flip) begin
            level_q  <= sync2[ch];
            stab_cnt <= '0;
            rise_q   <= sync2[ch];
            fall_q   <= ~sync2[ch];
          end else begin
            stab_cnt <= stab_cnt + CNT_W'(1);
          end
        end
      end
    end

    assign btn_level[ch] = level_q;
    assign btn_rise[ch]  = rise_q;
    assign btn_fall[ch]  = fall_q;

    if (LONG_CYCLES > 0) begin : g_long
      logic [HOLD_W-1:0] hold_cnt;
      logic              long_q;

      // Stage 3 boundary: press-duration counter and one-shot long pulse;
      // the strobe on which the level falls clears the counter instead, so a
      // long pulse never coincides with the release pulse.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hold_cnt <= '0;
          long_q   <= 1'b0;
        end else begin
          long_q <= 1'b0;
          if (sample_en) begin
            if (!level_q || flip) begin
              hold_cnt <= '0;
            end else begin
              long_q   <= (hold_cnt == HOLD_LAST);
              hold_cnt <= sat_inc(hold_cnt);
            end
          end
        end
      end

      assign btn_long[ch] = long_q;
    end else begin : g_no_long
      assign btn_long[ch] = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce (2 channels, 5 stable samples, 20-sample long
// press). A behavioural model built on a sliding window of strobed samples
// predicts every output; directed tasks also check absolute latencies.
module tb_multi_debounce;

  logic       clk;
  logic       rst_n;
  logic       sample_en;
  logic [1:0] btn_in;
  logic [1:0] btn_level, btn_rise, btn_fall, btn_long;

  int errors = 0;
  int checks = 0;

  multi_debounce #(
    .NUM_CH(2),
    .STABLE_CYCLES(5),
    .LONG_CYCLES(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample_en(sample_en),
    .btn_in(btn_in),
    .btn_level(btn_level),
    .btn_rise(btn_rise),
    .btn_fall(btn_fall),
    .btn_long(btn_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: inputs reach the filter two clocks late; the level
  // flips once the last 5 strobed samples all disagree with it; a press
  // reports long after 20 strobed samples at level 1.
  bit   [1:0] m_s1, m_s2, m_samp;
  bit         m_hist [2][5];
  int         m_hold [2];
  bit         m_diff, m_was;
  logic [1:0] e_level, e_rise, e_fall, e_long;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0;
      e_level = '0; e_rise = '0; e_fall = '0; e_long = '0;
      for (int c = 0; c < 2; c++) begin
        m_hold[c] = 0;
        for (int k = 0; k < 5; k++) m_hist[c][k] = 1'b0;
      end
    end else begin
      m_samp = m_s2;
      m_s2   = m_s1;
      m_s1   = btn_in;
      e_rise = '0; e_fall = '0; e_long = '0;
      if (sample_en) begin
        for (int c = 0; c < 2; c++) begin
          for (int k = 0; k < 4; k++) m_hist[c][k] = m_hist[c][k+1];
          m_hist[c][4] = m_samp[c];
          m_was  = e_level[c];
          m_diff = 1'b1;
          for (int k = 0; k < 5; k++) if (m_hist[c][k] == m_was) m_diff = 1'b0;
          if (m_diff) begin
            e_level[c] = ~m_was;
            if (m_was) e_fall[c] = 1'b1;
            else       e_rise[c] = 1'b1;
          end
          if (!m_was || e_fall[c]) m_hold[c] = 0;
          else if (m_hold[c] < 20) begin
            m_hold[c]++;
            if (m_hold[c] == 20) e_long[c] = 1'b1;
          end
        end
      end
    end
  end

  wire [7:0] dut_vec = {btn_level, btn_rise, btn_fall, btn_long};
  wire [7:0] exp_vec = {e_level, e_rise, e_fall, e_long};

  task automatic test_reset;
    rst_n = 1'b0; btn_in = 2'b11; sample_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold got=%h exp=00", dut_vec);
      end
    end
    btn_in = 2'b00;
    rst_n  = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single_press;
    int rise_at = -1, rises = 0;
    btn_in = 2'b01;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL single_press cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (btn_rise[0]) begin rises++; if (rise_at < 0) rise_at = cyc; end
    end
    checks++;
    if (rise_at != 7 || rises != 1) begin
      errors++;
      $display("FAIL single_press_latency got=%0d/%0d exp=7/1", rise_at, rises);
    end
    checks++;
    if ({btn_level[1], btn_rise[1], btn_fall[1], btn_long[1]} !== 4'b0000) begin
      errors++;
      $display("FAIL single_press_ch1 got=%b exp=0000",
               {btn_level[1], btn_rise[1], btn_fall[1], btn_long[1]});
    end
    btn_in = 2'b00;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch;
    int rise_at = -1, rises = 0;
    btn_in = 2'b01;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec || btn_level[0] !== 1'b0) begin
        errors++;
        $display("FAIL glitch_pre got=%h exp=%h", dut_vec, exp_vec);
      end
    end
    btn_in = 2'b00;
    @(negedge clk);
    btn_in = 2'b01;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL glitch cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (btn_rise[0]) begin rises++; if (rise_at < 0) rise_at = cyc; end
    end
    checks++;
    if (rise_at != 7 || rises != 1) begin
      errors++;
      $display("FAIL glitch_latency got=%0d/%0d exp=7/1", rise_at, rises);
    end
    btn_in = 2'b00;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_long_press;
    int rise_at = -1, long_at = -1, longs = 0, fall_at = -1;
    btn_in = 2'b01;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL long_hold cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (btn_rise[0] && rise_at < 0) rise_at = cyc;
      if (btn_long[0]) begin longs++; if (long_at < 0) long_at = cyc; end
    end
    checks++;
    if (rise_at != 7 || long_at - rise_at != 20) begin
      errors++;
      $display("FAIL long_latency got=%0d exp=20", long_at - rise_at);
    end
    btn_in = 2'b00;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL long_release cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (btn_long[0]) longs++;
      if (btn_fall[0] && fall_at < 0) fall_at = cyc;
    end
    checks++;
    if (fall_at != 7 || longs != 1) begin
      errors++;
      $display("FAIL long_once got=%0d/%0d exp=7/1", fall_at, longs);
    end
  endtask

  task automatic test_both_channels;
    bit seen = 1'b0;
    btn_in = 2'b11;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL both cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (cyc == 7) seen = (btn_rise === 2'b11);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL both_rise_together got=0 exp=1");
    end
    btn_in = 2'b00;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_strobe;
    int strobes_at_rise = -1, strobes = 0;
    btn_in = 2'b01;
    for (int cyc = 0; cyc < 48; cyc++) begin
      sample_en = (cyc % 4 == 0);
      @(negedge clk);
      if (sample_en) strobes++;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL strobe cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      checks++;
      if (!sample_en && (|{btn_rise, btn_fall, btn_long})) begin
        errors++;
        $display("FAIL strobe_pulse_off cyc=%0d got=%h exp=0", cyc, {btn_rise, btn_fall});
      end
      if (btn_rise[0] && strobes_at_rise < 0) strobes_at_rise = strobes;
    end
    // Strobe 1 lands on edge 1 before sync2 holds the press; strobes 2..6 qualify.
    checks++;
    if (strobes_at_rise != 6) begin
      errors++;
      $display("FAIL strobe_latency got=%0d exp=6", strobes_at_rise);
    end
    sample_en = 1'b1;
    btn_in = 2'b00;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int rise_at = -1;
    btn_in = 2'b01;
    repeat (10) @(negedge clk);
    btn_in = 2'b00;
    repeat (5) @(negedge clk);
    checks++;
    if (btn_level[0] !== 1'b1 || dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL mid_prestate got=%h exp=%h", dut_vec, exp_vec);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 8'h00) begin
      errors++;
      $display("FAIL mid_async_clear got=%h exp=00", dut_vec);
    end
    btn_in = 2'b01;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL mid_restart cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      if (btn_rise[0] && rise_at < 0) rise_at = cyc;
    end
    checks++;
    if (rise_at != 7) begin
      errors++;
      $display("FAIL mid_restart_latency got=%0d exp=7", rise_at);
    end
    btn_in = 2'b00;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random;
    int div;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      div = ((cyc / 500) % 2 == 1) ? 3 : 40;
      for (int c = 0; c < 2; c++)
        if ($urandom_range(0, div - 1) == 0) btn_in[c] = ~btn_in[c];
      sample_en = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec);
      end
      for (int c = 0; c < 2; c++) begin
        if (32'(btn_rise[c]) + 32'(btn_fall[c]) + 32'(btn_long[c]) > 1) begin
          errors++;
          $display("FAIL random_exclusive cyc=%0d ch=%0d got=%b%b%b exp=one-hot",
                   cyc, c, btn_rise[c], btn_fall[c], btn_long[c]);
        end
      end
    end
    sample_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    btn_in = 2'b00;
    sample_en = 1'b1;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_glitch();
    test_long_press();
    test_both_channels();
    test_strobe();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
